// File: rtl/memory_access_stage.sv
// OTTER memory stage: one req/ack data-memory transaction per load/store, lane
// steering and load extension, plus the MEM/WB register feeding writeback.
module memory_access_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        MEMORY_CLOCK,
  input  logic        MEMORY_RESET_N,
  input  logic        EX_MS_VALID,
  input  logic [31:0] EXEC_PC_4,
  input  logic [31:0] EXEC_ALU_RESULT,
  input  logic [31:0] EXEC_RS2,
  input  logic [1:0]  EXEC_RF_WR_SEL,
  input  logic        EXEC_REGWRITE,
  input  logic        EXEC_MEMWRITE,
  input  logic        EXEC_MEMREAD2,
  input  logic [4:0]  EX_MS_RD,
  input  logic [2:0]  EX_MS_FUNCT3,
  output logic        MS_STALL,
  output logic        DMEM_REQ,
  output logic        DMEM_WE,
  output logic [31:0] DMEM_ADDR,
  output logic [3:0]  DMEM_BE,
  output logic [31:0] DMEM_WDATA,
  input  logic        DMEM_ACK,
  input  logic [31:0] DMEM_RDATA,
  output logic        MS_WB_VALID,
  output logic [31:0] MS_WB_PC_4,
  output logic [31:0] MS_WB_ALU_RESULT,
  output logic [31:0] MS_WB_LOAD_DATA,
  output logic [1:0]  MS_WB_RF_WR_SEL,
  output logic        MS_WB_REGWRITE,
  output logic [4:0]  MS_WB_RD,
  output logic        MS_MISALIGN,
  output logic        MS_BUS_ERR
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t      state_q, state_d;
  logic        req_q, req_d, we_q, we_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, cnt_q, cnt_d;
  logic [3:0]  be_q, be_d;
  logic        wb_valid_q, wb_valid_d, wb_regw_q, wb_regw_d;
  logic [31:0] wb_pc4_q, wb_pc4_d, wb_alu_q, wb_alu_d, wb_load_q, wb_load_d;
  logic [1:0]  wb_sel_q, wb_sel_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic        misalign_q, misalign_d, bus_err_q, bus_err_d;

  logic [1:0]  lane, size;
  logic        mem_op, misaligned;
  logic [3:0]  be_c;
  logic [31:0] wdata_c, load_ext, shifted;
  logic [15:0] half;
  logic        retire, retire_regw;
  logic [31:0] retire_load;

  assign lane = EXEC_ALU_RESULT[1:0];
  assign size = EX_MS_FUNCT3[1:0];
  assign mem_op = EXEC_MEMWRITE | EXEC_MEMREAD2;
  assign misaligned = (size == 2'b11) || (size == 2'b01 && lane[0]) ||
                      (size == 2'b10 && lane != 2'b00);

  always_comb begin
    be_c    = 4'b1111;
    wdata_c = EXEC_RS2;
    case (size)
      2'b00: begin
        be_c    = 4'b0001 << lane;
        wdata_c = {4{EXEC_RS2[7:0]}};
      end
      2'b01: begin
        be_c    = lane[1] ? 4'b1100 : 4'b0011;
        wdata_c = {2{EXEC_RS2[15:0]}};
      end
      default: ;
    endcase
  end

  // Lane/extension decode uses the held EXEC_* inputs, valid for the whole BUSY span.
  always_comb begin
    shifted  = DMEM_RDATA >> {lane, 3'b000};
    half     = lane[1] ? DMEM_RDATA[31:16] : DMEM_RDATA[15:0];
    load_ext = DMEM_RDATA;
    case (size)
      2'b00:   load_ext = EX_MS_FUNCT3[2] ? {24'h0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
      2'b01:   load_ext = EX_MS_FUNCT3[2] ? {16'h0, half} : {{16{half[15]}}, half};
      default: ;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    we_d        = we_q;
    addr_d      = addr_q;
    be_d        = be_q;
    wdata_d     = wdata_q;
    cnt_d       = cnt_q;
    misalign_d  = 1'b0;
    bus_err_d   = 1'b0;
    retire      = 1'b0;
    retire_regw = 1'b0;
    retire_load = '0;
    case (state_q)
      IDLE: begin
        if (EX_MS_VALID) begin
          if (!mem_op) begin
            retire      = 1'b1;
            retire_regw = EXEC_REGWRITE;
          end else if (misaligned) begin
            retire     = 1'b1;
            misalign_d = 1'b1;
          end else begin
            state_d = BUSY;
            req_d   = 1'b1;
            we_d    = EXEC_MEMWRITE;
            addr_d  = {EXEC_ALU_RESULT[31:2], 2'b00};
            be_d    = be_c;
            wdata_d = wdata_c;
            cnt_d   = '0;
          end
        end
      end
      BUSY: begin
        if (DMEM_ACK) begin
          state_d     = IDLE;
          req_d       = 1'b0;
          retire      = 1'b1;
          retire_regw = EXEC_REGWRITE;
          retire_load = EXEC_MEMWRITE ? '0 : load_ext;
        end else if (TIMEOUT_CYCLES != 0 && cnt_q == TIMEOUT_CYCLES - 1) begin
          state_d   = IDLE;
          req_d     = 1'b0;
          retire    = 1'b1;
          bus_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wb_valid_d = retire;
    wb_regw_d  = retire & retire_regw;
    wb_pc4_d   = retire ? EXEC_PC_4 : wb_pc4_q;
    wb_alu_d   = retire ? EXEC_ALU_RESULT : wb_alu_q;
    wb_load_d  = retire ? retire_load : wb_load_q;
    wb_sel_d   = retire ? EXEC_RF_WR_SEL : wb_sel_q;
    wb_rd_d    = retire ? EX_MS_RD : wb_rd_q;
  end

  always_ff @(posedge MEMORY_CLOCK or negedge MEMORY_RESET_N) begin
    if (!MEMORY_RESET_N) begin
      state_q    <= IDLE;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      be_q       <= '0;
      wdata_q    <= '0;
      cnt_q      <= '0;
      wb_valid_q <= 1'b0;
      wb_regw_q  <= 1'b0;
      wb_pc4_q   <= '0;
      wb_alu_q   <= '0;
      wb_load_q  <= '0;
      wb_sel_q   <= '0;
      wb_rd_q    <= '0;
      misalign_q <= 1'b0;
      bus_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      be_q       <= be_d;
      wdata_q    <= wdata_d;
      cnt_q      <= cnt_d;
      wb_valid_q <= wb_valid_d;
      wb_regw_q  <= wb_regw_d;
      wb_pc4_q   <= wb_pc4_d;
      wb_alu_q   <= wb_alu_d;
      wb_load_q  <= wb_load_d;
      wb_sel_q   <= wb_sel_d;
      wb_rd_q    <= wb_rd_d;
      misalign_q <= misalign_d;
      bus_err_q  <= bus_err_d;
    end
  end

  assign MS_STALL         = (state_q == BUSY);
  assign DMEM_REQ         = req_q;
  assign DMEM_WE          = we_q;
  assign DMEM_ADDR        = addr_q;
  assign DMEM_BE          = be_q;
  assign DMEM_WDATA       = wdata_q;
  assign MS_WB_VALID      = wb_valid_q;
  assign MS_WB_PC_4       = wb_pc4_q;
  assign MS_WB_ALU_RESULT = wb_alu_q;
  assign MS_WB_LOAD_DATA  = wb_load_q;
  assign MS_WB_RF_WR_SEL  = wb_sel_q;
  assign MS_WB_REGWRITE   = wb_regw_q;
  assign MS_WB_RD         = wb_rd_q;
  assign MS_MISALIGN      = misalign_q;
  assign MS_BUS_ERR       = bus_err_q;

endmodule

// File: tb/tb_memory_access_stage.sv
// Directed bench for memory_access_stage: lane steering, extension, stall
// timing, misalign/timeout faults and asynchronous reset mid-transaction.
module tb_memory_access_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid = 1'b0;
  logic [31:0] pc4 = '0, alu = '0, rs2 = '0, rdata = '0;
  logic [1:0]  wr_sel = '0;
  logic        regw = 1'b0, memw = 1'b0, memr = 1'b0, ack = 1'b0;
  logic [4:0]  rd = '0;
  logic [2:0]  funct3 = '0;
  logic        stall, req, we, wb_valid, wb_regw, misalign, bus_err;
  logic [31:0] addr, wdata, wb_pc4, wb_alu, wb_load;
  logic [3:0]  be;
  logic [1:0]  wb_sel;
  logic [4:0]  wb_rd;

  int unsigned errors = 0;
  int unsigned checks = 0;
  int unsigned n;

  memory_access_stage #(.TIMEOUT_CYCLES(4)) dut (
    .MEMORY_CLOCK(clk), .MEMORY_RESET_N(rst_n), .EX_MS_VALID(valid),
    .EXEC_PC_4(pc4), .EXEC_ALU_RESULT(alu), .EXEC_RS2(rs2),
    .EXEC_RF_WR_SEL(wr_sel), .EXEC_REGWRITE(regw), .EXEC_MEMWRITE(memw),
    .EXEC_MEMREAD2(memr), .EX_MS_RD(rd), .EX_MS_FUNCT3(funct3),
    .MS_STALL(stall), .DMEM_REQ(req), .DMEM_WE(we), .DMEM_ADDR(addr),
    .DMEM_BE(be), .DMEM_WDATA(wdata), .DMEM_ACK(ack), .DMEM_RDATA(rdata),
    .MS_WB_VALID(wb_valid), .MS_WB_PC_4(wb_pc4), .MS_WB_ALU_RESULT(wb_alu),
    .MS_WB_LOAD_DATA(wb_load), .MS_WB_RF_WR_SEL(wb_sel),
    .MS_WB_REGWRITE(wb_regw), .MS_WB_RD(wb_rd), .MS_MISALIGN(misalign),
    .MS_BUS_ERR(bus_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic mw, input logic mr, input logic rw,
                       input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    valid = v; memw = mw; memr = mr; regw = rw; funct3 = f3; alu = a; rs2 = d;
    pc4 = a + 32'h1000; rd = a[4:0]; wr_sel = 2'b10;
  endtask

  initial begin
    #12;
    check("rst_req", {31'h0, req}, 32'h0);
    check("rst_wbv", {31'h0, wb_valid}, 32'h0);
    check("rst_wb_alu", wb_alu, 32'h0);
    rst_n = 1'b1;
    step();

    // LB 0x103 -> byte 3 of 0x80FF1234 = 0x80, sign extended
    drive(1, 0, 1, 1, 3'b000, 32'h103, 32'h0);
    step();
    check("lb_req", {31'h0, req}, 32'h1);
    check("lb_addr", addr, 32'h100);
    check("lb_be", {28'h0, be}, 32'h8);
    check("lb_we", {31'h0, we}, 32'h0);
    check("lb_wbv_early", {31'h0, wb_valid}, 32'h0);
    ack = 1'b1; rdata = 32'h80FF1234;
    step();
    ack = 1'b0; valid = 1'b0;
    check("lb_wbv", {31'h0, wb_valid}, 32'h1);
    check("lb_data", wb_load, 32'hFFFFFF80);
    check("lb_regw", {31'h0, wb_regw}, 32'h1);
    check("lb_rd", {27'h0, wb_rd}, 32'h3);
    check("lb_pc4", wb_pc4, 32'h1103);
    check("lb_req_done", {31'h0, req}, 32'h0);
    step();
    check("bubble_wbv", {31'h0, wb_valid}, 32'h0);
    check("bubble_regw", {31'h0, wb_regw}, 32'h0);

    // LHU 0x102 -> upper half, zero extended
    drive(1, 0, 1, 1, 3'b101, 32'h102, 32'h0);
    step();
    check("lhu_be", {28'h0, be}, 32'hC);
    ack = 1'b1; rdata = 32'hBEEF0000;
    step();
    ack = 1'b0; valid = 1'b0;
    check("lhu_data", wb_load, 32'h0000BEEF);

    // SH 0x202, three wait cycles before ACK
    drive(1, 1, 0, 0, 3'b001, 32'h202, 32'hDEADBEEF);
    step();
    check("sh_be", {28'h0, be}, 32'hC);
    check("sh_wdata", wdata, 32'hBEEFBEEF);
    check("sh_we", {31'h0, we}, 32'h1);
    check("sh_addr", addr, 32'h200);
    n = 0;
    for (int i = 0; i < 4; i++) begin
      if (stall) n++;
      if (i == 3) ack = 1'b1;
      step();
    end
    ack = 1'b0; valid = 1'b0;
    if (stall) n++;
    check("sh_stall_cycles", n, 32'd4);
    check("sh_wbv", {31'h0, wb_valid}, 32'h1);
    check("sh_regw", {31'h0, wb_regw}, 32'h0);
    check("sh_load", wb_load, 32'h0);

    // LW 0x101: misaligned, no bus transaction
    drive(1, 0, 1, 1, 3'b010, 32'h101, 32'h0);
    step();
    valid = 1'b0;
    check("mis_req", {31'h0, req}, 32'h0);
    check("mis_pulse", {31'h0, misalign}, 32'h1);
    check("mis_wbv", {31'h0, wb_valid}, 32'h1);
    check("mis_regw", {31'h0, wb_regw}, 32'h0);
    step();
    check("mis_pulse_end", {31'h0, misalign}, 32'h0);

    // LW 0x300 with no ACK: times out after 4 REQ cycles
    drive(1, 0, 1, 1, 3'b010, 32'h300, 32'h0);
    step();
    valid = 1'b0;
    n = 0;
    for (int i = 0; i < 10 && req; i++) begin
      n++;
      step();
    end
    check("to_req_cycles", n, 32'd4);
    check("to_buserr", {31'h0, bus_err}, 32'h1);
    check("to_wbv", {31'h0, wb_valid}, 32'h1);
    check("to_regw", {31'h0, wb_regw}, 32'h0);
    ack = 1'b1;
    step();
    ack = 1'b0;
    check("to_buserr_end", {31'h0, bus_err}, 32'h0);
    check("idle_ack_ignored", {31'h0, wb_valid}, 32'h0);

    // Three back-to-back ALU ops
    drive(1, 0, 0, 1, 3'b000, 32'h11, 32'h0);
    step();
    drive(1, 0, 0, 1, 3'b000, 32'h22, 32'h0);
    check("alu1_wbv", {31'h0, wb_valid}, 32'h1);
    check("alu1_res", wb_alu, 32'h11);
    check("alu1_stall", {31'h0, stall}, 32'h0);
    step();
    drive(1, 0, 0, 1, 3'b000, 32'h33, 32'h0);
    check("alu2_wbv", {31'h0, wb_valid}, 32'h1);
    check("alu2_res", wb_alu, 32'h22);
    check("alu2_stall", {31'h0, stall}, 32'h0);
    step();
    valid = 1'b0;
    check("alu3_wbv", {31'h0, wb_valid}, 32'h1);
    check("alu3_res", wb_alu, 32'h33);
    check("alu3_load", wb_load, 32'h0);
    check("alu3_sel", {30'h0, wb_sel}, 32'h2);

    // Reset asserted mid-transaction
    drive(1, 0, 1, 1, 3'b010, 32'h400, 32'h0);
    step();
    check("rb_req", {31'h0, req}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("rb_req_drop", {31'h0, req}, 32'h0);
    check("rb_stall", {31'h0, stall}, 32'h0);
    check("rb_addr", addr, 32'h0);
    check("rb_wb_alu", wb_alu, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    valid = 1'b0;
    rst_n = 1'b1;
    step();
    check("rb_wbv", {31'h0, wb_valid}, 32'h0);
    step();
    check("rb_wbv2", {31'h0, wb_valid}, 32'h0);
    check("rb_req_after", {31'h0, req}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
